// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store ports.
// Data has priority; a streak counter bounds fetch starvation; a timeout turns a lost read into an error.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter logic [31:0] ERR_DATA        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic            r_src_data;
    logic [3:0]      r_streak;
    logic [TCW-1:0]  r_tcnt;

    logic            r_i_rvalid;
    logic [31:0]     r_i_rdata;
    logic            r_d_rvalid;
    logic [31:0]     r_d_rdata;
    logic            r_err;

    logic            w_fetch_win;
    logic            w_data_win;
    logic            w_timeout;

    // Fetch wins when alone, or when data has used up its streak allowance.
    assign w_fetch_win = i_req && (!d_req || (r_streak == 4'(MAX_DATA_STREAK)));
    assign w_data_win  = d_req && !w_fetch_win;
    assign w_timeout   = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        mem_req      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy  = 1'b0;
                i_gnt = rst_n && w_fetch_win;
                d_gnt = rst_n && w_data_win;
                if (w_fetch_win || w_data_win) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next_state = r_we ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_src_data <= 1'b0;
            r_streak   <= '0;
            r_tcnt     <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fetch_win) begin
                        r_addr     <= i_addr;
                        r_wdata    <= '0;
                        r_we       <= 1'b0;
                        r_src_data <= 1'b0;
                        r_streak   <= '0;
                    end else if (w_data_win) begin
                        r_addr     <= d_addr;
                        r_wdata    <= d_wdata;
                        r_we       <= d_we;
                        r_src_data <= 1'b1;
                        if (!i_req) begin
                            r_streak <= '0;
                        end else if (r_streak != 4'(MAX_DATA_STREAK)) begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        if (r_we) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= '0;
                        end else begin
                            r_tcnt <= '0;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid || w_timeout) begin
                        if (r_src_data) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= mem_rvalid ? mem_rdata : ERR_DATA;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= mem_rvalid ? mem_rdata : ERR_DATA;
                        end
                        r_err <= !mem_rvalid;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign mem_we    = (r_state == ISSUE) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (64),
        .ERR_DATA       (32'h0000_0013)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic test_reset;
        logic [199:0] outs;
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            outs = {i_gnt, d_gnt, i_rvalid, d_rvalid, err, mem_req, mem_we, busy,
                    i_rdata, d_rdata, mem_addr, mem_wdata};
            checks++;
            if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if ({d_gnt, i_gnt} !== 2'b10) begin errors++; $display("FAIL reset_release_gnt: got d,i=%b expected 10", {d_gnt, i_gnt}); end
        // Pull reset back before the edge so the grant is not taken.
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch;
        @(negedge clk); i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1; #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got i,d=%b expected 10", {i_gnt, d_gnt}); end
        @(negedge clk); i_req = 1'b0; i_addr = 32'hDEAD_0000; #1;
        checks++;
        if ({mem_req, mem_we, busy, i_rvalid} !== 4'b1010 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL fetch_issue: got req/we/busy/rv=%b addr=%h expected 1010 addr=00000100",
                               {mem_req, mem_we, busy, i_rvalid}, mem_addr);
        end
        @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; #1;
        checks++;
        if ({mem_req, i_rvalid} !== 2'b00) begin errors++; $display("FAIL fetch_wait: got req,rv=%b expected 00", {mem_req, i_rvalid}); end
        @(negedge clk); mem_rvalid = 1'b0; mem_rdata = '0; #1;
        checks++;
        if ({i_rvalid, d_rvalid, err, busy} !== 4'b1000 || i_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL fetch_resp: got irv/drv/err/busy=%b rdata=%h expected 1000 rdata=00500093",
                               {i_rvalid, d_rvalid, err, busy}, i_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0050_0093) begin
            errors++; $display("FAIL fetch_hold: got rv=%b rdata=%h expected 0 00500093", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; mem_ready = 1'b1; #1;
        checks++;
        if ({d_gnt, i_gnt} !== 2'b10) begin errors++; $display("FAIL b2b_dgnt: got d,i=%b expected 10", {d_gnt, i_gnt}); end
        @(negedge clk); d_req = 1'b0; #1;
        checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h3000) begin
            errors++; $display("FAIL b2b_load_issue: got req,we=%b addr=%h expected 10 addr=00003000", {mem_req, mem_we}, mem_addr);
        end
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        @(negedge clk); mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h104; #1;
        checks++;
        if ({d_rvalid, i_gnt} !== 2'b11 || d_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL b2b_resp_and_gnt: got drv,ignt=%b rdata=%h expected 11 rdata=11223344", {d_rvalid, i_gnt}, d_rdata);
        end
        @(negedge clk); i_req = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            errors++; $display("FAIL b2b_fetch_issue: got req=%b addr=%h expected 1 addr=00000104", mem_req, mem_addr);
        end
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        @(negedge clk); mem_rvalid = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'h55 || d_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL b2b_fetch_resp: got irv,drv=%b irdata=%h drdata=%h expected 10 00000055 11223344",
                               {i_rvalid, d_rvalid}, i_rdata, d_rdata);
        end
    endtask

    task automatic test_store;
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_BABE; #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b expected 1", d_gnt); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); d_req = 1'b0; d_addr = 32'hFFFF_0000; d_wdata = '0; mem_ready = (k == 3); #1;
            checks++;
            if ({mem_req, mem_we, d_rvalid} !== 3'b110 || mem_addr !== 32'h2000 || mem_wdata !== 32'hCAFE_BABE) begin
                errors++; $display("FAIL store_hold[%0d]: got req/we/rv=%b addr=%h wdata=%h expected 110 00002000 cafebabe",
                                   k, {mem_req, mem_we, d_rvalid}, mem_addr, mem_wdata);
            end
        end
        @(negedge clk); mem_ready = 1'b0; d_we = 1'b0; #1;
        checks++;
        if ({d_rvalid, i_rvalid, mem_req, busy} !== 4'b1000 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL store_ack: got drv/irv/req/busy=%b rdata=%h expected 1000 00000000",
                               {d_rvalid, i_rvalid, mem_req, busy}, d_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b expected 0", d_rvalid); end
    endtask

    task automatic test_starvation;
        logic [9:0] expect_fetch;
        int         n;
        expect_fetch = 10'b10000_10000; // bit k = 1 means grant k goes to fetch
        n = 0;
        @(negedge clk); i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (i_gnt || d_gnt) begin
                checks++;
                if ({i_gnt, d_gnt} !== {expect_fetch[n], !expect_fetch[n]}) begin
                    errors++; $display("FAIL starve_order[%0d]: got i,d=%b expected %b", n, {i_gnt, d_gnt},
                                       {expect_fetch[n], !expect_fetch[n]});
                end
                n++;
            end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL starve_count: got %0d grants expected 10", n); end
        @(negedge clk); i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0; #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL starve_drain: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout;
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; mem_ready = 1'b1; #1;
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL tmo_gnt: got %b expected 1", d_gnt); end
        @(negedge clk); d_req = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo_issue: got req=%b expected 1", mem_req); end
        for (int j = 0; j < 64; j++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if ({busy, d_rvalid, err, mem_req} !== 4'b1000) begin
                errors++; $display("FAIL tmo_wait[%0d]: got busy/drv/err/req=%b expected 1000", j, {busy, d_rvalid, err, mem_req});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({d_rvalid, err, i_rvalid, busy} !== 4'b1100 || d_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL tmo_resp: got drv/err/irv/busy=%b rdata=%h expected 1100 00000013",
                               {d_rvalid, err, i_rvalid, busy}, d_rdata);
        end
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD; #1;
        checks++;
        if ({d_rvalid, err} !== 2'b00) begin errors++; $display("FAIL tmo_pulse: got drv,err=%b expected 00", {d_rvalid, err}); end
        @(negedge clk); mem_rvalid = 1'b0; #1;
        checks++;
        if ({d_rvalid, i_rvalid, err, busy} !== 4'b0000 || d_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL tmo_late_rvalid: got drv/irv/err/busy=%b rdata=%h expected 0000 00000013",
                               {d_rvalid, i_rvalid, err, busy}, d_rdata);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk); i_req = 1'b1; i_addr = 32'h200; mem_ready = 1'b1; #1;
        checks++;
        if (i_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 1", i_gnt); end
        @(negedge clk); i_req = 1'b0;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if ({busy, mem_req} !== 2'b10) begin errors++; $display("FAIL rst_mid_wait: got busy,req=%b expected 10", {busy, mem_req}); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077; #1;
        checks++;
        if ({busy, i_rvalid, d_rvalid} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_abandon: got busy/irv/drv=%b expected 000", {busy, i_rvalid, d_rvalid});
        end
        @(negedge clk); mem_rvalid = 1'b0; #1;
        checks++;
        if ({busy, i_rvalid, d_rvalid} !== 3'b000 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_noresp: got busy/irv/drv=%b irdata=%h expected 000 00000000",
                               {busy, i_rvalid, d_rvalid}, i_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_store();
        test_starvation();
        test_timeout();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port memory between the core's instruction-fetch port and its load/store data port. Only one transaction is in flight at a time. Data requests have priority over fetch requests, and an anti-starvation counter bounds how long fetch can be held off. Responses are registered and sent back to the requester that issued the transaction. A timeout converts a missing read response into an error response.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch request is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 64, cycles spent in WAIT_R without mem_rvalid before an error response (>=2)
ERR_DATA, 32'h0000_0013, rdata returned on timeout (RV32 NOP)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
i_req  in  1  fetch request
i_addr  in  32  fetch address
i_gnt  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data valid, or store done (1-cycle pulse)
d_rdata  out  32  load data (0 on store completion)
err  out  1  timeout error pulse, coincident with the rvalid it qualifies
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  memory read data valid
mem_rdata  in  32  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state = IDLE, streak counter = 0, timeout counter = 0. All outputs are 0, including the data buses.
- Reset mid-transaction: the transaction is abandoned and no response is delivered.
- FSM states:
  - IDLE: selects a winner.
  - ISSUE: drives mem_req.
  - WAIT_R: waits for read data.
- IDLE:
  - If any request is present, pulse the winner's gnt this cycle (gnt is combinational from the req inputs and state).
  - Latch addr, we, wdata and source (fetch stores we = 0, wdata = 0), then go to ISSUE. Requester inputs are don't-care after the gnt.
- Arbitration:
  - d_req alone: data wins.
  - i_req alone: fetch wins.
  - Both: data wins, unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - Incremented on a data grant while i_req is high; saturates at MAX_DATA_STREAK.
  - Cleared on any fetch grant, and on a data grant while i_req is low.
- ISSUE:
  - mem_req = 1 with the latched values; they are held stable until mem_ready.
  - mem_ready with we = 1: next cycle d_rvalid = 1, d_rdata = 0; go to IDLE.
  - mem_ready with we = 0: go to WAIT_R, timeout counter = 0.
- WAIT_R:
  - mem_req = 0.
  - mem_rvalid: next cycle, the source's rvalid = 1 and its rdata = the registered mem_rdata; go to IDLE.
  - Otherwise the counter increments. If the counter == TIMEOUT_CYCLES-1 without rvalid: next cycle rvalid = 1, rdata = ERR_DATA, err = 1; go to IDLE.
- Ignored inputs: mem_rvalid in IDLE or ISSUE; mem_ready outside ISSUE.
- Response hold: rvalid/err are 1-cycle pulses. rdata holds its last value until the next response to the same port.
- Back-to-back: the cycle the FSM re-enters IDLE (the cycle the rvalid pulse is visible), a new grant may be issued.
- Minimum latency with mem_ready and mem_rvalid in their first eligible cycles:
  - Read: gnt at N, mem_req at N+1, mem_rvalid at N+2, rvalid at N+3.
  - Write: ack at N+2.
- busy = (state != IDLE).
- No alignment checking; addresses pass through unchanged.

Test Plan:
- Reset: hold rst_n = 0 with i_req = d_req = 1 -> all outputs 0 and no gnt. Release -> d_gnt the next cycle.
- Single fetch: i_addr = 0x100, mem_ready = 1, mem_rvalid two cycles after gnt with rdata = 0x00500093 -> i_rvalid = 1 with i_rdata = 0x00500093 exactly 3 cycles after i_gnt; mem_addr = 0x100 during ISSUE.
- Store: d_we = 1, d_addr = 0x2000, d_wdata = 0xCAFEBABE, mem_ready delayed 3 cycles -> mem_req/addr/wdata stable for 4 cycles; d_rvalid pulses with d_rdata = 0.
- Starvation: i_req and d_req held high continuously, mem always responding -> grant order D, D, D, D, I, D, D, D, D, I.
- Timeout: d_req load, mem_rvalid never asserted -> d_rvalid = 1, err = 1, d_rdata = 0x00000013 after TIMEOUT_CYCLES in WAIT_R; the FSM returns to IDLE. A late mem_rvalid afterwards is ignored.
- Reset mid-read: assert rst_n = 0 during WAIT_R, then mem_rvalid -> no i_rvalid/d_rvalid; busy = 0.
